boot_loader: RTL and testbench

Serial program loader that sits directly upstream of the CPU core. It receives a framed program image on a UART line, writes it byte-by-byte into program memory, and holds the CPU's active-low reset until a frame with a valid checksum has been loaded. It then releases the CPU to run from the loaded image.

---
 rtl/boot_loader_pkg.sv | 32 +++
 rtl/boot_loader_if.sv | 11 +
 rtl/boot_uart_rx.sv | 100 ++++++++++
 rtl/boot_loader.sv | 155 +++++++++++++++
 tb/tb_boot_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the serial boot loader.
// The optional inter-byte timeout is enabled with the BOOT_TIMEOUT_EN macro.
package boot_loader_pkg;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
  localparam int         BOOT_ADDR_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CHK,
    ST_RUN
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // A frame is in progress from the first header byte through the checksum.
  function automatic logic is_busy(boot_state_e s);
    return (s == ST_ADDR_H) || (s == ST_ADDR_L) || (s == ST_LEN_H) ||
           (s == ST_LEN_L)  || (s == ST_DATA)   || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Program-memory write port driven by the boot loader.
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic                   MEM_WE;
  logic [BOOT_ADDR_W-1:0] MEM_ADDR;
  logic [7:0]             MEM_WDATA;

  modport master (output MEM_WE, output MEM_ADDR, output MEM_WDATA);
  modport slave  (input  MEM_WE, input  MEM_ADDR, input  MEM_WDATA);
endinterface

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module boot_uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  rx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Falling edge only, so a line held low after a bad stop bit is not re-read as a start.
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// Frame FSM that loads a UART program image into memory and gates the CPU reset.
// Define BOOT_TIMEOUT_EN to abort frames stalled for TIMEOUT_CLKS between bytes.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 65536
) (
  input  logic          MAINCLK,
  input  logic          MAINRST,
  input  logic          RX_IN,
  output logic          CPU_RST,
  output logic          LOAD_BUSY,
  output logic          LOAD_ERR,
  boot_loader_if.master mem
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  boot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (MAINCLK),
    .rst_n     (MAINRST),
    .rx_in     (RX_IN),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  boot_state_e            state_q, state_d;
  logic [7:0]             sum_q, sum_d;
  logic [15:0]            len_q, len_d;
  logic [BOOT_ADDR_W-1:0] addr_q, addr_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic [BOOT_ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   busy;
  logic                   tmo_hit;

  assign busy = is_busy(state_q);

`ifdef BOOT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts clocks since the last byte_valid, inclusive of that cycle.
  always_comb begin
    tmo_d = '0;
    if (byte_valid)  tmo_d = TMO_W'(1);
    else if (busy)   tmo_d = tmo_q + TMO_W'(1);
  end

  assign tmo_hit = busy && !byte_valid && (tmo_d == TMO_W'(TIMEOUT_CLKS));

  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    len_d   = len_q;
    addr_d  = addr_q;
    err_d   = err_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    if (byte_valid) begin
      if (state_q inside {ST_ADDR_H, ST_ADDR_L, ST_LEN_H, ST_LEN_L, ST_DATA})
        sum_d = sum_q + byte_data;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (byte_data == BOOT_SYNC_BYTE) begin
            state_d = ST_ADDR_H;
            sum_d   = '0;
            err_d   = 1'b0;
            addr_d  = '0;
          end
        end
        ST_ADDR_H: begin
          addr_d  = {byte_data, addr_q[7:0]};
          state_d = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d  = {addr_q[15:8], byte_data};
          state_d = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_d   = {byte_data, 8'h00};
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          len_d   = {len_q[15:8], byte_data};
          state_d = ({len_q[15:8], byte_data} == 16'h0000) ? ST_CHK : ST_DATA;
        end
        ST_DATA: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = byte_data;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
          if (len_q == 16'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (byte_data == sum_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((frame_err && busy) || tmo_hit) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign CPU_RST       = (state_q == ST_RUN);
  assign LOAD_BUSY     = busy;
  assign LOAD_ERR      = err_q;
  assign mem.MEM_WE    = we_q;
  assign mem.MEM_ADDR  = maddr_q;
  assign mem.MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued at stimulus time, a monitor checks them.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic cpu_rst, busy, err;

  boot_loader_if mem ();

  boot_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) u_dut (
    .MAINCLK  (clk),
    .MAINRST  (rst_n),
    .RX_IN    (rx),
    .CPU_RST  (cpu_rst),
    .LOAD_BUSY(busy),
    .LOAD_ERR (err),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   bv_cnt = 0;
  int   wr_cnt = 0;
  int   last_bv = 0;
  int   rise_lag = -1;
  int   fall_lag = -1;
  int   err_lag = -1;
  logic cpu_prev = 1'b0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every write strobe and tracks output edge timing.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (u_dut.byte_valid) begin
        bv_cnt++;
        last_bv = cyc;
      end
      if (cpu_rst && !cpu_prev) rise_lag = cyc - last_bv;
      if (!cpu_rst && cpu_prev) fall_lag = cyc - last_bv;
      if (err && !err_prev)     err_lag  = cyc - last_bv;
      cpu_prev = cpu_rst;
      err_prev = err;
      if (mem.MEM_WE) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   mem.MEM_ADDR, mem.MEM_WDATA);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {8'h00, mem.MEM_ADDR, mem.MEM_WDATA}, {8'h00, e.a, e.d});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    if (!stop) tick(CPB);
  endtask

  // Sends n bytes from v, most significant byte first.
  task automatic send_vec(input logic [127:0] v, input int n);
    for (int k = 0; k < n; k++) send_byte(v[8*(n-1-k) +: 8], 1'b1);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_std3();
    push_wr(16'h1000, 8'h11);
    push_wr(16'h1001, 8'h22);
    push_wr(16'h1002, 8'h33);
  endtask

  task automatic do_reset(input bit check_vals);
    rst_n = 1'b0;
    tick(100);
    if (check_vals) begin
      check("rst_cpu_rst", cpu_rst, 0);
      check("rst_mem_we", mem.MEM_WE, 0);
      check("rst_mem_addr", mem.MEM_ADDR, 0);
      check("rst_mem_wdata", mem.MEM_WDATA, 0);
      check("rst_load_busy", busy, 0);
      check("rst_load_err", err, 0);
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  initial begin
    int bv0;

    // Valid load, reload, framing error, glitch
    do_reset(1'b1);
    push_std3();
    wr_cnt = 0;
    rise_lag = -1;
    send_vec(128'hA5_10_00_00_03_11_22_33_79, 9);
    tick(20);
    check("valid_wr_count", wr_cnt, 3);
    check("valid_cpu_rst", cpu_rst, 1);
    check("valid_rise_lag", rise_lag, 1);
    check("valid_load_err", err, 0);
    check("valid_busy", busy, 0);

    fall_lag = -1;
    send_byte(8'hA5, 1'b1);
    tick(5);
    check("reload_cpu_rst", cpu_rst, 0);
    check("reload_fall_lag", fall_lag, 1);
    check("reload_busy", busy, 1);

    push_wr(16'h1000, 8'h11);
    wr_cnt = 0;
    send_vec(128'h10_00_00_03_11, 5);
    send_byte(8'h22, 1'b0);
    tick(20);
    check("ferr_load_err", err, 1);
    check("ferr_busy", busy, 0);
    check("ferr_wr_count", wr_cnt, 1);
    check("ferr_cpu_rst", cpu_rst, 0);

    bv0 = bv_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(200);
    check("glitch_no_byte", bv_cnt - bv0, 0);
    check("glitch_busy", busy, 0);

    // Bad checksum followed by a good frame
    do_reset(1'b0);
    push_std3();
    wr_cnt = 0;
    send_vec(128'hA5_10_00_00_03_11_22_33_78, 9);
    tick(20);
    check("badchk_wr_count", wr_cnt, 3);
    check("badchk_cpu_rst", cpu_rst, 0);
    check("badchk_load_err", err, 1);
    check("badchk_state_idle", u_dut.state_q, ST_IDLE);
    push_std3();
    send_vec(128'hA5_10_00_00_03_11_22_33_79, 9);
    tick(20);
    check("recover_load_err", err, 0);
    check("recover_cpu_rst", cpu_rst, 1);

    // Address wrap (checksum FF+FF+00+02+AA+BB = 0x365 -> 0x65)
    do_reset(1'b0);
    push_wr(16'hFFFF, 8'hAA);
    push_wr(16'h0000, 8'hBB);
    wr_cnt = 0;
    send_vec(128'hA5_FF_FF_00_02_AA_BB_65, 8);
    tick(20);
    check("wrap_wr_count", wr_cnt, 2);
    check("wrap_cpu_rst", cpu_rst, 1);

    // Zero length
    do_reset(1'b0);
    wr_cnt = 0;
    send_vec(128'hA5_00_00_00_00_00, 6);
    tick(20);
    check("zlen_wr_count", wr_cnt, 0);
    check("zlen_cpu_rst", cpu_rst, 1);
    check("zlen_load_err", err, 0);

    // Reset mid-frame after a completed load
    do_reset(1'b0);
    push_std3();
    send_vec(128'hA5_10_00_00_03_11_22_33_79, 9);
    send_vec(128'hA5_10_00, 3);
    tick(2);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_rst", cpu_rst, 0);
    check("midrst_mem_we", mem.MEM_WE, 0);
    check("midrst_mem_addr", mem.MEM_ADDR, 0);
    check("midrst_mem_wdata", mem.MEM_WDATA, 0);
    check("midrst_busy", busy, 0);
    check("midrst_load_err", err, 0);
    tick(100);
    rst_n = 1'b1;
    tick(5);
    push_std3();
    wr_cnt = 0;
    send_vec(128'hA5_10_00_00_03_11_22_33_79, 9);
    tick(20);
    check("midrst_reload_wr_count", wr_cnt, 3);
    check("midrst_reload_cpu_rst", cpu_rst, 1);

`ifdef BOOT_TIMEOUT_EN
    // Stall after LEN_L
    do_reset(1'b0);
    err_lag = -1;
    send_vec(128'hA5_10_00_00_03, 5);
    for (int i = 0; i < 3 * TMO && !err; i++) tick(1);
    tick(2);
    check("tmo_load_err", err, 1);
    check("tmo_lag", err_lag, TMO);
    check("tmo_busy", busy, 0);
    check("tmo_cpu_rst", cpu_rst, 0);
`endif

    check("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
